// File: rtl/verilog_ethernet_pack.sv
// Shared Ethernet receive definitions.
//   octet_t          : one byte on the receive byte stream
//   CRC32_*          : reflected CRC-32 polynomial, init value and good-frame residue
//   ST_* / rx_state_t: receive FSM state encoding
//   crc32_byte_next  : advances a reflected CRC-32 register by one octet, LSB first
package verilog_ethernet_pack;

  typedef logic [7:0] octet_t;

  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

  typedef logic [2:0] rx_state_t;
  localparam rx_state_t ST_IDLE     = 3'd0;
  localparam rx_state_t ST_PREAMBLE = 3'd1;
  localparam rx_state_t ST_DATA     = 3'd2;
  localparam rx_state_t ST_END      = 3'd3;
  localparam rx_state_t ST_DROP     = 3'd4;

  function automatic logic [31:0] crc32_byte_next(input logic [31:0] crc, input octet_t octet);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c >> 1) ^ ((c[0] ^ octet[i]) ? CRC32_POLY : 32'h0);
    end
    return c;
  endfunction

endpackage

// File: rtl/mii_rx_crc32.sv
// Byte-wide CRC-32 register for the MII receive path.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   init_i        : load the init value (start of frame); wins over en_i
//   en_i, data_i  : fold one octet into the register
//   residue_ok_o  : register holds the good-frame residue (frame incl. FCS is intact)
module mii_rx_crc32
  import verilog_ethernet_pack::*;
(
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   init_i,
  input  logic   en_i,
  input  octet_t data_i,
  output logic   residue_ok_o
);

  logic [31:0] crc_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     crc_q <= CRC32_INIT;
    else if (init_i) crc_q <= CRC32_INIT;
    else if (en_i)   crc_q <= crc32_byte_next(crc_q, data_i);
  end

  assign residue_ok_o = (crc_q == CRC32_RESIDUE);

endmodule

// File: rtl/mii_rx_frame_receiver.sv
// MII receive front-end: strips preamble/SFD, assembles nibbles into bytes, checks FCS,
// length, alignment and PHY errors, and emits the frame without FCS as a byte stream.
//   i_clock, i_reset_n         : MII rx_clk, asynchronous active-low reset
//   i_rx_d, i_rx_dv, i_rx_er   : MII receive pins
//   o_data/o_valid/o_sop/o_eop : byte stream, DA first, FCS removed
//   o_good/o_crc_err/o_len_err/o_err : frame status, meaningful only with o_eop
//   o_good_count, o_bad_count  : wrapping frame counters
//   o_dbg_state                : current receive FSM state (ST_* encoding)
// Stream handshake: o_valid is a one-cycle strobe qualifying o_data/o_sop/o_eop; there is no
// ready, because the MII cannot be stalled, so the consumer must take every strobed byte.
module mii_rx_frame_receiver
  import verilog_ethernet_pack::*;
#(
  parameter int unsigned P_MIN_PREAMBLE_NIBBLES = 8,
  parameter int unsigned P_MIN_FRAME_BYTES      = 64,
  parameter int unsigned P_MAX_FRAME_BYTES      = 1518,
  parameter int unsigned P_CNT_WIDTH            = 16
) (
  input  logic                   i_clock,
  input  logic                   i_reset_n,
  input  logic [3:0]             i_rx_d,
  input  logic                   i_rx_dv,
  input  logic                   i_rx_er,
  output logic [7:0]             o_data,
  output logic                   o_valid,
  output logic                   o_sop,
  output logic                   o_eop,
  output logic                   o_good,
  output logic                   o_crc_err,
  output logic                   o_len_err,
  output logic                   o_err,
  output logic [P_CNT_WIDTH-1:0] o_good_count,
  output logic [P_CNT_WIDTH-1:0] o_bad_count,
  output logic [2:0]             o_dbg_state
);

  localparam int unsigned PRE_W = $clog2(P_MIN_PREAMBLE_NIBBLES + 2);
  localparam int unsigned LEN_W = $clog2(P_MAX_FRAME_BYTES + 2);
  localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(P_MAX_FRAME_BYTES + 1);

  // Input register stage; dv resets high so a frame already in progress at reset release
  // is not mistaken for a rising edge.
  logic [3:0] rx_d_q;
  logic       rx_dv_q, rx_er_q, dv_prev_q;

  rx_state_t        state_q, state_d;
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic             hi_phase_q, hi_phase_d;
  logic [3:0]       lo_nib_q, lo_nib_d;
  octet_t           byte_q, byte_d;
  logic             byte_vld_q, byte_vld_d;
  logic             frm_err_q, frm_err_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             first_q, first_d;
  // Delay line holding the last 5 bytes; element 0 is the oldest once the line is full.
  logic [4:0][7:0]  dl_q, dl_d;
  logic [2:0]       dl_cnt_q, dl_cnt_d;

  logic [7:0]             data_q, data_d;
  logic                   valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;
  logic                   good_q, good_d, crc_err_q, crc_err_d;
  logic                   len_err_q, len_err_d, err_q, err_d;
  logic [P_CNT_WIDTH-1:0] good_cnt_q, good_cnt_d, bad_cnt_q, bad_cnt_d;

  logic crc_init, residue_ok, pre_start, st_crc, st_len, st_err;

  mii_rx_crc32 u_crc (
    .clk_i        (i_clock),
    .rst_ni       (i_reset_n),
    .init_i       (crc_init),
    .en_i         (byte_vld_q),
    .data_i       (byte_q),
    .residue_ok_o (residue_ok)
  );

  function automatic rx_state_t pre_state(input logic [3:0] nib, input logic [PRE_W-1:0] cnt);
    if (nib == 4'h5) return ST_PREAMBLE;
    if (nib == 4'hD && cnt >= PRE_W'(P_MIN_PREAMBLE_NIBBLES)) return ST_DATA;
    return ST_DROP;
  endfunction

  function automatic logic [PRE_W-1:0] pre_cnt_next(input logic [3:0] nib,
                                                    input logic [PRE_W-1:0] cnt);
    if (nib == 4'h5 && cnt < PRE_W'(P_MIN_PREAMBLE_NIBBLES)) return cnt + PRE_W'(1);
    return cnt;
  endfunction

  assign pre_start = rx_dv_q & ~dv_prev_q;
  assign st_crc    = ~residue_ok;
  assign st_len    = (len_q < LEN_W'(P_MIN_FRAME_BYTES)) || (len_q > LEN_W'(P_MAX_FRAME_BYTES));
  assign st_err    = frm_err_q;

  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    hi_phase_d = hi_phase_q;
    lo_nib_d   = lo_nib_q;
    byte_d     = byte_q;
    byte_vld_d = 1'b0;
    frm_err_d  = frm_err_q;
    len_d      = len_q;
    first_d    = first_q;
    dl_d       = dl_q;
    dl_cnt_d   = dl_cnt_q;
    crc_init   = 1'b0;
    data_d     = data_q;
    valid_d    = 1'b0;
    sop_d      = 1'b0;
    eop_d      = 1'b0;
    good_d     = 1'b0;
    crc_err_d  = 1'b0;
    len_err_d  = 1'b0;
    err_d      = 1'b0;
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (pre_start) begin
          state_d   = pre_state(rx_d_q, '0);
          pre_cnt_d = pre_cnt_next(rx_d_q, '0);
        end
      end
      ST_PREAMBLE: begin
        if (!rx_dv_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d   = pre_state(rx_d_q, pre_cnt_q);
          pre_cnt_d = pre_cnt_next(rx_d_q, pre_cnt_q);
        end
      end
      ST_DATA: begin
        if (rx_er_q) frm_err_d = 1'b1;
        if (rx_dv_q) begin
          if (!hi_phase_q) begin
            lo_nib_d   = rx_d_q;
            hi_phase_d = 1'b1;
          end else begin
            byte_d     = {rx_d_q, lo_nib_q};
            byte_vld_d = 1'b1;
            hi_phase_d = 1'b0;
          end
        end else begin
          state_d = ST_END;
          if (hi_phase_q) frm_err_d = 1'b1;  // dv fell between the two nibbles of a byte
        end
      end
      ST_END: begin
        // A full delay line means at least 5 bytes: the oldest one is the last payload byte.
        if (dl_cnt_q == 3'd5) begin
          valid_d   = 1'b1;
          data_d    = dl_q[0];
          sop_d     = first_q;
          eop_d     = 1'b1;
          crc_err_d = st_crc;
          len_err_d = st_len;
          err_d     = st_err;
          good_d    = ~(st_crc | st_len | st_err);
          if (~(st_crc | st_len | st_err)) good_cnt_d = good_cnt_q + P_CNT_WIDTH'(1);
          else                             bad_cnt_d  = bad_cnt_q + P_CNT_WIDTH'(1);
        end
        state_d = ST_IDLE;
        // A 1-cycle gap puts the next frame's first nibble in this cycle.
        if (pre_start) begin
          state_d   = pre_state(rx_d_q, '0);
          pre_cnt_d = pre_cnt_next(rx_d_q, '0);
        end
      end
      ST_DROP: begin
        if (!rx_dv_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_DATA && state_q != ST_DATA) begin
      crc_init   = 1'b1;
      hi_phase_d = 1'b0;
      frm_err_d  = 1'b0;
      len_d      = '0;
      first_d    = 1'b1;
      dl_cnt_d   = 3'd0;
    end

    if (byte_vld_q) begin
      if (len_q != LEN_SAT) len_d = len_q + LEN_W'(1);
      if (dl_cnt_q == 3'd5) begin
        valid_d = 1'b1;
        data_d  = dl_q[0];
        sop_d   = first_q;
        first_d = 1'b0;
      end else begin
        dl_cnt_d = dl_cnt_q + 3'd1;
      end
      dl_d = {byte_q, dl_q[4:1]};
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rx_d_q     <= '0;
      rx_dv_q    <= 1'b1;
      rx_er_q    <= 1'b0;
      dv_prev_q  <= 1'b1;
      state_q    <= ST_IDLE;
      pre_cnt_q  <= '0;
      hi_phase_q <= 1'b0;
      lo_nib_q   <= '0;
      byte_q     <= '0;
      byte_vld_q <= 1'b0;
      frm_err_q  <= 1'b0;
      len_q      <= '0;
      first_q    <= 1'b0;
      dl_q       <= '0;
      dl_cnt_q   <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      good_q     <= 1'b0;
      crc_err_q  <= 1'b0;
      len_err_q  <= 1'b0;
      err_q      <= 1'b0;
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
    end else begin
      rx_d_q     <= i_rx_d;
      rx_dv_q    <= i_rx_dv;
      rx_er_q    <= i_rx_er;
      dv_prev_q  <= rx_dv_q;
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      hi_phase_q <= hi_phase_d;
      lo_nib_q   <= lo_nib_d;
      byte_q     <= byte_d;
      byte_vld_q <= byte_vld_d;
      frm_err_q  <= frm_err_d;
      len_q      <= len_d;
      first_q    <= first_d;
      dl_q       <= dl_d;
      dl_cnt_q   <= dl_cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      sop_q      <= sop_d;
      eop_q      <= eop_d;
      good_q     <= good_d;
      crc_err_q  <= crc_err_d;
      len_err_q  <= len_err_d;
      err_q      <= err_d;
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
    end
  end

  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_sop        = sop_q;
  assign o_eop        = eop_q;
  assign o_good       = good_q;
  assign o_crc_err    = crc_err_q;
  assign o_len_err    = len_err_q;
  assign o_err        = err_q;
  assign o_good_count = good_cnt_q;
  assign o_bad_count  = bad_cnt_q;
  assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_mii_rx_frame_receiver.sv
// Bench for mii_rx_frame_receiver: directed frames from the feature list plus random frames.
// A frame-level model pushes every expected output byte (with status) into exp_q; a monitor
// pops and compares whenever o_valid is seen.
module tb_mii_rx_frame_receiver;

  localparam int W = 14;  // {data[7:0], sop, eop, good, crc_err, len_err, err}

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  rx_d = '0;
  logic        rx_dv = 1'b0;
  logic        rx_er = 1'b0;
  logic [7:0]  o_data;
  logic        o_valid, o_sop, o_eop, o_good, o_crc_err, o_len_err, o_err;
  logic [15:0] o_good_count, o_bad_count;
  logic [2:0]  o_dbg_state;

  always #20 clk = ~clk;

  mii_rx_frame_receiver dut (
    .i_clock      (clk),
    .i_reset_n    (rst_n),
    .i_rx_d       (rx_d),
    .i_rx_dv      (rx_dv),
    .i_rx_er      (rx_er),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .o_sop        (o_sop),
    .o_eop        (o_eop),
    .o_good       (o_good),
    .o_crc_err    (o_crc_err),
    .o_len_err    (o_len_err),
    .o_err        (o_err),
    .o_good_count (o_good_count),
    .o_bad_count  (o_bad_count),
    .o_dbg_state  (o_dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [7:0]   frm[$];
  int n_checks = 0;
  int n_fail   = 0;
  int mon_good = 0;
  int mon_bad  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model helpers ----------------
  function automatic logic [31:0] crc_of(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, frm[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic append_fcs();
    logic [31:0] f;
    f = crc_of(frm.size());
    frm.push_back(f[7:0]);
    frm.push_back(f[15:8]);
    frm.push_back(f[23:16]);
    frm.push_back(f[31:24]);
  endtask

  task automatic build_arp(input int pad);
    logic [7:0] hdr [0:41];
    hdr = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h08, 8'h00, 8'h27, 8'hE9, 8'h5E, 8'h81,
            8'h08, 8'h06, 8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01,
            8'h08, 8'h00, 8'h27, 8'hE9, 8'h5E, 8'h81, 8'hC0, 8'hA8, 8'h01, 8'h0A,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hC0, 8'hA8, 8'h01, 8'h01};
    frm.delete();
    for (int i = 0; i < 42; i++) frm.push_back(hdr[i]);
    for (int i = 0; i < pad; i++) frm.push_back(8'h00);
    append_fcs();
  endtask

  task automatic build_random(input int n_payload);
    frm.delete();
    for (int i = 0; i < n_payload; i++) frm.push_back(8'($urandom_range(0, 255)));
    append_fcs();
  endtask

  // ---------------- driver ----------------
  task automatic drive_nib(input logic [3:0] n, input logic er);
    @(negedge clk);
    rx_d  = n;
    rx_dv = 1'b1;
    rx_er = er;
  endtask

  // n5: count of 0x5 preamble nibbles before 0xD; bad_pos: index of a 0x7 among them (-1 none);
  // er_byte: byte carrying rx_er (-1 none); extra: append one stray nibble;
  // rst_byte: pulse reset before this byte (-1 none); gap: dv-low cycles afterwards.
  task automatic send_frame(input int n5, input int bad_pos, input int er_byte, input bit extra,
                            input int rst_byte, input int gap);
    int n;
    logic pre_ok, fcs_ok, len_err, err, crc_err, good;
    logic [31:0] fcs_rx;
    n = frm.size();
    pre_ok = (bad_pos < 0) && (n5 >= 8);
    fcs_ok = 1'b0;
    if (n >= 4) begin
      fcs_rx = {frm[n-1], frm[n-2], frm[n-3], frm[n-4]};
      fcs_ok = (fcs_rx == crc_of(n - 4));
    end
    crc_err = ~fcs_ok;
    len_err = (n < 64) || (n > 1518);
    err     = (er_byte >= 0 && er_byte < n) || extra;
    good    = ~(crc_err | len_err | err);
    if (pre_ok && n >= 5) begin
      for (int i = 0; i <= n - 5; i++) begin
        logic last;
        last = (i == n - 5);
        exp_q.push_back({frm[i], i == 0, last, last & good, last & crc_err,
                         last & len_err, last & err});
      end
    end

    for (int i = 0; i < n5; i++)
      drive_nib((i == bad_pos) ? 4'h7 : 4'h5, 1'($urandom_range(0, 1)));
    drive_nib(4'hD, 1'b0);
    for (int i = 0; i < n; i++) begin
      if (i == rst_byte) begin
        #10;
        rst_n = 1'b0;
        exp_q.delete();
        mon_good = 0;
        mon_bad  = 0;
        #5;
        check("rst_valid", {63'h0, o_valid}, 64'h0);
        check("rst_good_count", {48'h0, o_good_count}, 64'h0);
        @(posedge clk);
        #5;
        rst_n = 1'b1;
      end
      drive_nib(frm[i][3:0], i == er_byte);
      drive_nib(frm[i][7:4], i == er_byte);
    end
    if (extra) drive_nib(4'($urandom_range(0, 15)), 1'b0);
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      rx_dv = 1'b0;
      rx_d  = '0;
      rx_er = 1'b0;
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    check("drain", 64'(exp_q.size()), 64'h0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin : mon
    logic [W-1:0] e;
    if (rst_n && o_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", {63'h0, o_valid}, 64'h0);
      end else begin
        e = exp_q.pop_front();
        check("byte", {50'h0, o_data, o_sop, o_eop, o_good, o_crc_err, o_len_err, o_err},
              {50'h0, e});
        if (e[4]) begin
          if (e[3]) mon_good++;
          else      mon_bad++;
          check("good_count", {48'h0, o_good_count}, 64'(mon_good));
          check("bad_count", {48'h0, o_bad_count}, 64'(mon_bad));
        end
      end
    end
  end

  initial begin
    #(40 * 60000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n, erb, n5, bp;
    logic [7:0] flip;
    #30;
    check("reset_valid", {63'h0, o_valid}, 64'h0);
    check("reset_eop", {63'h0, o_eop}, 64'h0);
    check("reset_data", {56'h0, o_data}, 64'h0);
    check("reset_good_count", {48'h0, o_good_count}, 64'h0);
    check("reset_bad_count", {48'h0, o_bad_count}, 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 1: good 64-byte ARP request
    build_arp(18);
    send_frame(15, -1, -1, 0, -1, 12);
    wait_drain();
    check("t1_good_count", {48'h0, o_good_count}, 64'd1);

    // 2: FCS bit 0 flipped
    build_arp(18);
    frm[60] = frm[60] ^ 8'h01;
    send_frame(15, -1, -1, 0, -1, 12);
    wait_drain();
    check("t2_bad_count", {48'h0, o_bad_count}, 64'd1);

    // 3: 60-byte runt with valid FCS
    build_arp(14);
    send_frame(15, -1, -1, 0, -1, 12);
    wait_drain();

    // 4: rx_er on byte 20, then a stray trailing nibble
    build_arp(18);
    send_frame(15, -1, 20, 0, -1, 12);
    build_arp(18);
    send_frame(15, -1, -1, 1, -1, 12);
    wait_drain();
    check("t4_bad_count", {48'h0, o_bad_count}, 64'd4);

    // 5: broken preambles are dropped, then a good frame
    build_arp(18);
    send_frame(15, 6, -1, 0, -1, 6);
    build_arp(18);
    send_frame(4, -1, -1, 0, -1, 6);
    wait_drain();
    check("t5_good_count_held", {48'h0, o_good_count}, 64'd1);
    check("t5_bad_count_held", {48'h0, o_bad_count}, 64'd4);
    build_arp(18);
    send_frame(15, -1, -1, 0, -1, 12);
    wait_drain();
    check("t5_good_count", {48'h0, o_good_count}, 64'd2);

    // 6: reset at byte 30 with dv held high, then a good frame
    build_arp(18);
    send_frame(15, -1, -1, 0, 30, 12);
    build_arp(18);
    send_frame(15, -1, -1, 0, -1, 12);
    wait_drain();
    check("t6_good_count", {48'h0, o_good_count}, 64'd1);
    check("t6_bad_count", {48'h0, o_bad_count}, 64'd0);

    // length boundaries (DA..FCS = payload + 4), back-to-back with 1-cycle gaps
    build_random(60);   send_frame(8, -1, -1, 0, -1, 1);
    build_random(59);   send_frame(8, -1, -1, 0, -1, 1);
    build_random(1);    send_frame(8, -1, -1, 0, -1, 1);
    build_random(0);    send_frame(8, -1, -1, 0, -1, 1);
    build_random(1514); send_frame(8, -1, -1, 0, -1, 1);
    build_random(1515); send_frame(8, -1, -1, 0, -1, 3);
    wait_drain();

    // random frames
    for (int k = 0; k < 24; k++) begin
      build_random(int'($urandom_range(0, 110)));
      n = frm.size();
      if ($urandom_range(0, 3) == 0) begin
        flip = 8'h01 << $urandom_range(0, 7);
        frm[$urandom_range(0, n - 1)] ^= flip;
      end
      erb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      n5  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(2, 7)) : int'($urandom_range(8, 15));
      bp  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, n5 - 1)) : -1;
      send_frame(n5, bp, erb, ($urandom_range(0, 5) == 0), -1, int'($urandom_range(1, 3)));
    end
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
